mem_bus_adapter: RTL and testbench

- Upstream stage of memory_top. Converts a 6502-side single-beat request/ack bus (16-bit address) into memory_top's rd_enable/wr_enable strobes.
- Handles address-window decode, holds off while memory_top reports busy (including post-reset initialisation), and waits out the fixed read latency.
- Returns read data to the CPU with a one-cycle ack.

---
 rtl/mem_bus_adapter.sv | 173 +++++++++++++++++
 tb/tb_mem_bus_adapter.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_adapter.sv
`default_nettype none
// ============================================================================
// Module      : mem_bus_adapter
// Description : Bridges a 6502-side single-beat req/ack bus onto memory_top's
//               rd_enable/wr_enable strobes. Decodes the address window, holds
//               off while memory_top is busy (including its post-reset init),
//               waits out the fixed read latency and acks the CPU.
//               Optional busy-wait timeout: define MEM_ADAPTER_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_bus_adapter #(
  parameter int                          DATA_WIDTH     = 8,
  parameter int                          ADDR_WIDTH     = 12,
  parameter int                          CPU_ADDR_WIDTH = 16,
  parameter logic [CPU_ADDR_WIDTH-1:0]   BASE_ADDR      = 16'h0000,
  parameter int                          RD_LATENCY     = 1,
  parameter logic [DATA_WIDTH-1:0]       OPEN_BUS_VALUE = 8'hFF,
  parameter int                          TIMEOUT_CYCLES = 1024
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      cpu_req,
  input  logic                      cpu_we,
  input  logic [CPU_ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0]     cpu_wdata,
  output logic [DATA_WIDTH-1:0]     cpu_rdata,
  output logic                      cpu_ack,
  output logic                      cpu_err,
  output logic                      mem_rd_enable,
  output logic                      mem_wr_enable,
  output logic [ADDR_WIDTH-1:0]     mem_addr,
  output logic [DATA_WIDTH-1:0]     mem_wr_data,
  input  logic                      mem_busy,
  input  logic [DATA_WIDTH-1:0]     mem_rd_data
);

  // Elaboration-time sanity check on the latency/timeout settings.
  generate
    if (RD_LATENCY < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_param
      $error("mem_bus_adapter: RD_LATENCY and TIMEOUT_CYCLES must be >= 1");
    end
  endgenerate

  localparam int LAT_W = $clog2(RD_LATENCY + 1);
  localparam int WIN   = 2 ** ADDR_WIDTH;

  // Window bounds kept one bit wider than the CPU address so a window that
  // ends at the top of the CPU address space does not wrap to zero.
  localparam logic [CPU_ADDR_WIDTH:0] C_BASE_EXT  = (CPU_ADDR_WIDTH + 1)'(BASE_ADDR);
  localparam logic [CPU_ADDR_WIDTH:0] C_LIMIT_EXT = C_BASE_EXT + (CPU_ADDR_WIDTH + 1)'(WIN);

  typedef enum logic [2:0] {
    S_INIT      = 3'd0,
    S_IDLE      = 3'd1,
    S_WAIT_BUSY = 3'd2,
    S_ISSUE     = 3'd3,
    S_WAIT_RD   = 3'd4,
    S_RESP      = 3'd5
  } state_t;

  state_t                  r_state;
  state_t                  w_state_next;
  logic                    r_init_seen;   // busy was low on the previous INIT cycle
  logic                    r_we;
  logic [DATA_WIDTH-1:0]   r_wdata;
  logic [ADDR_WIDTH-1:0]   r_mem_addr;
  logic [DATA_WIDTH-1:0]   r_cpu_rdata;
  logic [LAT_W-1:0]        r_lat_cnt;
  logic                    w_hit;
  logic [ADDR_WIDTH-1:0]   w_mem_addr;
  logic                    w_lat_done;
  logic                    w_to_expire;

  assign w_hit      = ({1'b0, cpu_addr} >= C_BASE_EXT) && ({1'b0, cpu_addr} < C_LIMIT_EXT);
  assign w_mem_addr = ADDR_WIDTH'(cpu_addr - BASE_ADDR);
  assign w_lat_done = (r_lat_cnt == LAT_W'(RD_LATENCY - 1));

`ifdef MEM_ADAPTER_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] r_to_cnt;
  logic            r_err;
  assign w_to_expire = mem_busy && (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
`else
  assign w_to_expire = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_INIT;
    else        r_state <= w_state_next;
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_INIT:      if (!mem_busy && r_init_seen) w_state_next = S_IDLE;
      S_IDLE:      if (cpu_req) begin
                     if (!w_hit)        w_state_next = S_RESP;
                     else if (mem_busy) w_state_next = S_WAIT_BUSY;
                     else               w_state_next = S_ISSUE;
                   end
      S_WAIT_BUSY: if (!mem_busy)       w_state_next = S_ISSUE;
                   else if (w_to_expire) w_state_next = S_RESP;
      S_ISSUE:     w_state_next = r_we ? S_RESP : S_WAIT_RD;
      S_WAIT_RD:   if (w_lat_done)      w_state_next = S_RESP;
      S_RESP:      w_state_next = S_IDLE;
      default:     w_state_next = S_INIT;
    endcase
  end

  // Request capture, latency/timeout counting and read-data return.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_init_seen <= 1'b0;
      r_we        <= 1'b0;
      r_wdata     <= '0;
      r_mem_addr  <= '0;
      r_cpu_rdata <= '0;
      r_lat_cnt   <= '0;
`ifdef MEM_ADAPTER_TIMEOUT_EN
      r_to_cnt    <= '0;
      r_err       <= 1'b0;
`endif
    end else begin
      r_init_seen <= (r_state == S_INIT) && !mem_busy;
      case (r_state)
        S_IDLE: if (cpu_req) begin
          r_we    <= cpu_we;
          r_wdata <= cpu_wdata;
          if (w_hit)        r_mem_addr  <= w_mem_addr;
          else if (!cpu_we) r_cpu_rdata <= OPEN_BUS_VALUE;
`ifdef MEM_ADAPTER_TIMEOUT_EN
          r_to_cnt <= '0;
          r_err    <= 1'b0;
`endif
        end
`ifdef MEM_ADAPTER_TIMEOUT_EN
        S_WAIT_BUSY: if (mem_busy) begin
          r_to_cnt <= r_to_cnt + TO_W'(1);
          if (w_to_expire) begin
            r_err <= 1'b1;
            if (!r_we) r_cpu_rdata <= OPEN_BUS_VALUE;
          end
        end
`endif
        S_ISSUE: r_lat_cnt <= '0;
        S_WAIT_RD: begin
          r_lat_cnt <= r_lat_cnt + LAT_W'(1);
          if (w_lat_done) r_cpu_rdata <= mem_rd_data;
        end
        default: ;
      endcase
    end
  end

  // Outputs decoded from the registered state, so they are glitch-free and 0 in reset.
  always_comb begin
    mem_rd_enable = (r_state == S_ISSUE) && !r_we;
    mem_wr_enable = (r_state == S_ISSUE) &&  r_we;
    cpu_ack       = (r_state == S_RESP);
`ifdef MEM_ADAPTER_TIMEOUT_EN
    cpu_err       = (r_state == S_RESP) && r_err;
`else
    cpu_err       = 1'b0;
`endif
    mem_addr      = r_mem_addr;
    mem_wr_data   = r_wdata;
    cpu_rdata     = r_cpu_rdata;
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_adapter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_bus_adapter
// Description : Self-checking bench for mem_bus_adapter. Plays memory_top
//               (array + read pipeline) and predicts every transaction from
//               the adapter's timing rules with plain arithmetic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_bus_adapter;
  localparam int          LAT  = 3;
  localparam int          TO   = 16;
  localparam int          WIN  = 4096;
  localparam logic [15:0] BASE = 16'hF000;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we, cpu_ack, cpu_err;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata, cpu_rdata;
  logic        mem_rd_enable, mem_wr_enable, mem_busy;
  logic [11:0] mem_addr;
  logic [7:0]  mem_wr_data, mem_rd_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_bus_adapter #(
    .DATA_WIDTH(8), .ADDR_WIDTH(12), .CPU_ADDR_WIDTH(16), .BASE_ADDR(BASE),
    .RD_LATENCY(LAT), .OPEN_BUS_VALUE(8'hFF), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset(reset), .cpu_req(cpu_req), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .cpu_ack(cpu_ack), .cpu_err(cpu_err), .mem_rd_enable(mem_rd_enable),
    .mem_wr_enable(mem_wr_enable), .mem_addr(mem_addr), .mem_wr_data(mem_wr_data),
    .mem_busy(mem_busy), .mem_rd_data(mem_rd_data)
  );

  function automatic logic [7:0] init_val(input int a);
    return 8'((a * 29) ^ (a >> 4) ^ 'h5A);
  endfunction

  // memory_top stand-in: writes land in the array, reads appear LAT cycles
  // after the strobe; junk is shifted in otherwise so mistimed capture shows.
  logic [7:0] mem_arr [WIN];
  logic       written [WIN];
  logic [7:0] pipe [LAT];
  always @(posedge clk) begin
    if (mem_wr_enable) begin
      mem_arr[mem_addr] <= mem_wr_data;
      written[mem_addr] <= 1'b1;
    end
    pipe[0] <= mem_rd_enable ? (written[mem_addr] ? mem_arr[mem_addr] : init_val(int'(mem_addr)))
                             : 8'($urandom);
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign mem_rd_data = pipe[LAT-1];

  // Reference contents of the window as the CPU should see it.
  logic [7:0] ref_mem [WIN];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic outputs_zero(input string tag);
    check(tag, {31'd0, mem_rd_enable | mem_wr_enable | cpu_ack | cpu_err
                | (|mem_addr) | (|mem_wr_data) | (|cpu_rdata)}, 32'd0);
  endtask

  // One CPU transaction, started in an IDLE cycle (cycle 0 = capture).
  // mem_busy is high for cycles 0..busy_cyc-1.
  task automatic run_txn(input string tag, input logic we, input logic [15:0] addr,
                         input logic [7:0] wd, input int busy_cyc);
    int off, exp_ack, exp_strobe, strobes, strobe_cyc, ack_cyc;
    bit hit, to, moved;
    logic strobe_wr, err_seen;
    logic [11:0] strobe_addr;
    logic [7:0] strobe_wd, rd_seen, exp_rd;
    off = int'(addr) - int'(BASE);
    hit = (off >= 0) && (off < WIN);
    to  = 1'b0;
`ifdef MEM_ADAPTER_TIMEOUT_EN
    to  = hit && (busy_cyc - 1 >= TO);
`endif
    if (!hit)    exp_ack = 1;
    else if (to) exp_ack = 1 + TO;
    else if (we) exp_ack = 2 + busy_cyc;
    else         exp_ack = 2 + busy_cyc + LAT;
    exp_strobe = (hit && !to) ? 1 + busy_cyc : -1;
    exp_rd     = (hit && !to) ? ref_mem[off] : 8'hFF;
    strobes = 0; strobe_cyc = -1; ack_cyc = -1; moved = 1'b0;
    strobe_wr = 1'b0; strobe_addr = '0; strobe_wd = '0; rd_seen = '0; err_seen = 1'b0;

    @(negedge clk);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
    mem_busy = (busy_cyc > 0);
    for (int n = 1; n <= exp_ack + 20 && ack_cyc < 0; n++) begin
      @(negedge clk);
      mem_busy  = (n < busy_cyc);
      cpu_we    = 1'($urandom);
      cpu_addr  = 16'($urandom);
      cpu_wdata = 8'($urandom);
      strobes += int'(mem_rd_enable) + int'(mem_wr_enable);
      if ((mem_rd_enable || mem_wr_enable) && strobe_cyc < 0) begin
        strobe_cyc = n; strobe_wr = mem_wr_enable; strobe_addr = mem_addr; strobe_wd = mem_wr_data;
      end
      if (strobe_cyc >= 0 && (mem_addr !== strobe_addr || mem_wr_data !== strobe_wd)) moved = 1'b1;
      if (cpu_ack) begin ack_cyc = n; rd_seen = cpu_rdata; err_seen = cpu_err; end
    end
    cpu_req  = 1'b0;
    mem_busy = 1'b0;

    check($sformatf("%s.ack_cycle", tag), ack_cyc, exp_ack);
    check($sformatf("%s.strobes", tag), strobes, (exp_strobe >= 0) ? 1 : 0);
    if (exp_strobe >= 0) begin
      check($sformatf("%s.strobe_cycle", tag), strobe_cyc, exp_strobe);
      check($sformatf("%s.strobe_is_write", tag), {31'd0, strobe_wr}, {31'd0, we});
      check($sformatf("%s.mem_addr", tag), {20'd0, strobe_addr}, 32'(off[11:0]));
      check($sformatf("%s.addr_data_stable", tag), {31'd0, moved}, 32'd0);
      if (we) check($sformatf("%s.mem_wr_data", tag), {24'd0, strobe_wd}, {24'd0, wd});
    end
    check($sformatf("%s.cpu_err", tag), {31'd0, err_seen}, {31'd0, to});
    if (!we) check($sformatf("%s.cpu_rdata", tag), {24'd0, rd_seen}, {24'd0, exp_rd});
    @(negedge clk);
    check($sformatf("%s.ack_single", tag), {31'd0, cpu_ack}, 32'd0);
    if (!we) check($sformatf("%s.rdata_held", tag), {24'd0, cpu_rdata}, {24'd0, exp_rd});
    if (hit && !to && we) ref_mem[off] = wd;
  endtask

  // Global bound so a stuck DUT can never hang the run.
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s_strobes, s_strobe, s_ack, idle_c;
    logic [7:0] s_rd;
    bit bad;
    for (int i = 0; i < WIN; i++) ref_mem[i] = init_val(i);
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    mem_busy = 1'b1; reset = 1'b0;

    // Startup: reset 10 cycles, busy for 50 cycles after release, read at cycle 5.
    repeat (10) @(negedge clk);
    outputs_zero("reset_outputs");
    reset = 1'b1;
    s_strobes = 0; s_strobe = -1; s_ack = -1; s_rd = '0;
    idle_c = 50 + 2;  // two consecutive not-busy samples (cycles 50,51)
    for (int n = 0; n < 120 && s_ack < 0; n++) begin
      if (n > 0) begin
        @(negedge clk);
        s_strobes += int'(mem_rd_enable) + int'(mem_wr_enable);
        if (mem_rd_enable && s_strobe < 0) s_strobe = n;
        if (cpu_ack) begin s_ack = n; s_rd = cpu_rdata; end
      end
      mem_busy = (n < 50);
      if (n == 5) begin cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'hF2A4; end
    end
    cpu_req = 1'b0;
    check("startup.strobes", s_strobes, 1);
    check("startup.strobe_cycle", s_strobe, idle_c + 1);
    check("startup.ack_cycle", s_ack, idle_c + 2 + LAT);
    check("startup.cpu_rdata", {24'd0, s_rd}, {24'd0, ref_mem[12'h2A4]});
    @(negedge clk);

    // Write then read back.
    run_txn("wr_a5", 1'b1, 16'hF123, 8'hA5, 0);
    run_txn("rd_a5", 1'b0, 16'hF123, 8'h00, 0);
    // Window edges.
    run_txn("rd_lo_edge", 1'b0, 16'hF000, 8'h00, 0);
    run_txn("rd_hi_edge", 1'b0, 16'hFFFF, 8'h00, 0);
    run_txn("rd_below", 1'b0, 16'hEFFF, 8'h00, 0);
    run_txn("wr_below", 1'b1, 16'hEFFF, 8'h77, 0);
    run_txn("wr_hi_edge", 1'b1, 16'hFFFF, 8'h5C, 0);
    run_txn("rd_hi_back", 1'b0, 16'hFFFF, 8'h00, 0);
    run_txn("rd_zero", 1'b0, 16'h0000, 8'h00, 2);
    // Busy while a write is captured.
    run_txn("wr_busy7", 1'b1, 16'hF456, 8'h3E, 7);
    run_txn("rd_busy7", 1'b0, 16'hF456, 8'h00, 7);

    // Randomized traffic.
    for (int t = 0; t < 60; t++) begin
      logic [15:0] a;
      int r;
      r = int'($urandom_range(0, 9));
      if (r < 4)      a = 16'(int'(BASE) + int'($urandom_range(0, 15)));
      else if (r < 7) a = 16'(int'(BASE) + int'($urandom_range(0, WIN - 1)));
      else if (r < 8) a = 16'(16'hFFF0 + $urandom_range(0, 15));
      else            a = 16'($urandom_range(0, 16'hEFFF));
      run_txn($sformatf("rand%0d", t), 1'($urandom), a, 8'($urandom),
              ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 5)) : 0);
    end

`ifdef MEM_ADAPTER_TIMEOUT_EN
    run_txn("timeout_rd", 1'b0, 16'hF789, 8'h00, 1000);
`endif

    // Reset during WAIT_RD aborts the read and re-enters INIT.
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'hF010; mem_busy = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    cpu_req = 1'b0;
    #1;
    outputs_zero("midrd.outputs_immediate");
    bad = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (cpu_ack || mem_rd_enable || mem_wr_enable) bad = 1'b1;
    end
    check("midrd.no_ack_in_reset", {31'd0, bad}, 32'd0);
    reset = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'hF020; cpu_wdata = 8'h3C;
    s_strobes = 0; s_strobe = -1; s_ack = -1;
    for (int n = 1; n <= 20 && s_ack < 0; n++) begin
      @(negedge clk);
      s_strobes += int'(mem_rd_enable) + int'(mem_wr_enable);
      if (mem_wr_enable && s_strobe < 0) s_strobe = n;
      if (cpu_ack) s_ack = n;
    end
    cpu_req = 1'b0;
    check("midrd.reinit_strobes", s_strobes, 1);
    check("midrd.reinit_strobe_cycle", s_strobe, 3);
    check("midrd.reinit_ack_cycle", s_ack, 4);
    ref_mem[12'h020] = 8'h3C;
    @(negedge clk);
    run_txn("midrd.readback", 1'b0, 16'hF020, 8'h00, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
